dm_tx_streamer: RTL and testbench
=================================

# dm_tx_streamer

Read-side streaming engine for a PE data memory. On a `start` command it walks a contiguous address window of the 256-entry data-memory read port, absorbs the BRAM's 1-cycle read latency, and presents the words on a valid/ready transmit stream toward the next PE's transfer-write (`web`/`dinb`) port. A 2-entry skid buffer makes backpressure lossless while keeping full throughput.

## Interface
- `DATA_W`, 32, word width (matches data-memory width `DATA_WIDTH*2`)
- `ADDR_W`, 8, data-memory address width; depth is 2^ADDR_W
- `clk`  in  1  clock; every register updates on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  command strobe; sampled only when `busy`=0
- `base_addr`  in  ADDR_W  first address, captured on an accepted `start`
- `len`  in  ADDR_W+1  word count, 0..256, captured on an accepted `start`
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle pulse on completion
- `mem_rden`  out  1  data-memory read enable
- `mem_raddr`  out  ADDR_W  data-memory read address
- `mem_rdata`  in  DATA_W  read data, valid the cycle after `mem_rden`=1
- `tx_valid`  out  1  stream word valid
- `tx_data`  out  DATA_W  stream word
- `tx_last`  out  1  qualifies the final word of the command
- `tx_ready`  in  1  downstream accept

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: `start`=1 with `len`>0 -> capture base/len, remaining-to-issue `iss_cnt`=len, remaining-to-send `snd_cnt`=len, go RUN. `start`=1 with `len`=0 -> no reads, `done` pulses the next cycle, stay IDLE.
- RUN: each cycle, issue a read (`mem_rden`=1, `mem_raddr`=next address) when `iss_cnt`>0 and `fifo_count + inflight - pop < 2`, where `pop` = `tx_valid & tx_ready` this cycle and `inflight` = read issued the previous cycle. Issue -> address +1 modulo 2^ADDR_W (0xFF wraps to 0x00), `iss_cnt` -1. `iss_cnt` reaches 0 -> FLUSH.
- Returning `mem_rdata` is written into the skid FIFO on the cycle it is valid; FIFO never overflows by the credit rule.
- `tx_valid` = FIFO non-empty; `tx_data` = FIFO head; `tx_last` = `tx_valid` and `snd_cnt`=1.
- Each handshake decrements `snd_cnt`. The handshake with `snd_cnt`=1 -> IDLE, `done`=1 next cycle.
- `mem_rden`=0 whenever no read is issued; `mem_raddr` holds its last value.
- `start` while `busy`=1 is ignored; captured fields unaffected.
- `tx_data` is held stable while `tx_valid`=1 and `tx_ready`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_rden`=0, `mem_raddr`=0, `tx_valid`=0, `tx_last`=0, `tx_data`=0; FIFO empty, counters 0, state IDLE. Reset mid-command aborts immediately; an in-flight read return is discarded; no `done`.
- `start` in cycle 0 -> `busy`=1 from cycle 1; first read (`mem_raddr`=base) in cycle 1; first `tx_valid` in cycle 3.
- `tx_ready` held 1: one word per cycle, word k in cycle 3+k, last word in cycle N+2, `done` in cycle N+3 with `busy`=0 that same cycle. A new `start` is accepted in cycle N+3.
- `tx_ready`=0: at most 2 words buffered, no further reads issued; on release, throughput returns to 1 word/cycle with no bubble beyond the read latency.

## Test plan
- base=0x10, len=4, mem[a]=0xA000_0000+a, `tx_ready`=1 -> reads 0x10..0x13 in cycles 1-4; `tx_data` 0xA000_0010..0xA000_0013 in cycles 3-6; `tx_last` in cycle 6; `done` in cycle 7.
- base=0xFE, len=4 -> read addresses 0xFE, 0xFF, 0x00, 0x01; data order preserved.
- len=8, `tx_ready` toggling 1,0,0,1,... randomly -> all 8 words delivered in order, none duplicated or dropped, never more than 2 reads ahead of delivery, `tx_data` stable while stalled.
- len=0 -> no `mem_rden`, no `tx_valid`, `done` one cycle after `start`, `busy` stays 0.
- len=256, base=0x8F, `tx_ready`=1 -> 256 words covering every address once, wrapping 0xFF->0x00, ending at 0x8E; `done` in cycle 259; `start` pulsed mid-command ignored.
- `rst` asserted after 3 of 6 words -> next cycle all outputs at reset values; a fresh `start` (base=0x20, len=2) then runs cleanly with no stale data.

Source files
------------

// File: rtl/dm_tx_streamer.sv
// dm_tx_streamer: walks a data-memory address window and streams the words out
// over valid/ready, absorbing the 1-cycle read latency with a 2-entry skid FIFO.
`default_nettype none

module dm_tx_streamer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_last,
  input  logic              tx_ready
);

  localparam logic [ADDR_W:0]   ONE_CNT  = 1;
  localparam logic [ADDR_W-1:0] ONE_ADDR = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W:0]     iss_cnt;
  logic [ADDR_W:0]     snd_cnt;
  logic [ADDR_W-1:0]   next_addr;
  logic [ADDR_W-1:0]   last_addr;
  logic                inflight;
  logic [DATA_W-1:0]   fifo [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          fifo_count;
  logic                pop;
  logic                issue;
  logic [2:0]          occupancy;

  assign tx_valid  = (fifo_count != 2'd0);
  assign tx_data   = fifo[rd_ptr];
  assign tx_last   = tx_valid && (snd_cnt == ONE_CNT);
  assign pop       = tx_valid && tx_ready;
  assign busy      = (state != IDLE);

  // Credit check: a word leaving this cycle frees a slot for a read issued now.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
  assign issue     = (state == RUN) && (iss_cnt != '0) &&
                     (occupancy < (3'd2 + {2'b00, pop}));

  // The address only moves on an issue, so it holds when the port is idle.
  assign mem_rden  = issue;
  assign mem_raddr = issue ? next_addr : last_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done       <= 1'b0;
      iss_cnt    <= '0;
      snd_cnt    <= '0;
      next_addr  <= '0;
      last_addr  <= '0;
      inflight   <= 1'b0;
      fifo[0]    <= '0;
      fifo[1]    <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;

      if (issue) begin
        last_addr <= next_addr;
        next_addr <= next_addr + ONE_ADDR;
        iss_cnt   <= iss_cnt - ONE_CNT;
      end

      if (inflight) begin
        fifo[wr_ptr] <= mem_rdata;
        wr_ptr       <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        snd_cnt <= snd_cnt - ONE_CNT;
      end

      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              next_addr <= base_addr;
              iss_cnt   <= len;
              snd_cnt   <= len;
              state     <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue && (iss_cnt == ONE_CNT)) begin
            state <= FLUSH;
          end
          if (pop && (snd_cnt == ONE_CNT)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        FLUSH: begin
          if (pop && (snd_cnt == ONE_CNT)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_tx_streamer.sv
// tb_dm_tx_streamer: directed checks of the data-memory transmit streamer
// against a behavioural memory where mem[a] = 0xA000_0000 + a.
`default_nettype none

module tb_dm_tx_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic [8:0]  len = 9'd0;
  logic        busy;
  logic        done;
  logic        mem_rden;
  logic [7:0]  mem_raddr;
  logic [31:0] mem_rdata = 32'h0;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_last;
  logic        tx_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  dm_tx_streamer #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_rden  (mem_rden),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  // 1-cycle latency memory model
  always @(posedge clk) begin
    if (mem_rden) mem_rdata <= 32'hA000_0000 | {24'h0, mem_raddr};
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  {31'b0, busy},     32'd0);
    check({tag, "_done"},  {31'b0, done},     32'd0);
    check({tag, "_rden"},  {31'b0, mem_rden}, 32'd0);
    check({tag, "_raddr"}, {24'b0, mem_raddr}, 32'd0);
    check({tag, "_valid"}, {31'b0, tx_valid}, 32'd0);
    check({tag, "_last"},  {31'b0, tx_last},  32'd0);
    check({tag, "_data"},  tx_data,           32'd0);
  endtask

  // mode 0: tx_ready held 1; mode 1: random tx_ready.
  task automatic run(input string tag, input logic [7:0] b, input logic [8:0] n,
                     input int mode, input int pulse_at);
    int cyc = 0, got = 0, issued = 0, lead = 0, lead_max = 0;
    int data_err = 0, addr_err = 0, last_err = 0, unstable = 0, busy_err = 0;
    int first_cyc = -1, last_cyc = -1, done_cyc = -1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'h0;
    logic [7:0]  a;
    @(posedge clk); #1;
    base_addr = b; len = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 600) begin
      tx_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (cyc == pulse_at);
      base_addr = 8'h00; len = 9'd5;
      @(negedge clk);
      if (mem_rden) begin
        a = b + issued[7:0];
        if (mem_raddr !== a) addr_err++;
        issued++;
      end
      if (prev_stall && tx_data !== prev_data) unstable++;
      if (tx_valid && tx_ready) begin
        a = b + got[7:0];
        if (tx_data !== (32'hA000_0000 | {24'h0, a})) data_err++;
        if (tx_last !== (got == int'(n) - 1)) last_err++;
        if (got == 0) first_cyc = cyc;
        if (tx_last) last_cyc = cyc;
        got++;
      end
      lead = issued - got;
      if (lead > lead_max) lead_max = lead;
      if (n == 0 && busy) busy_err++;
      if (done) begin
        done_cyc = cyc;
        if (busy) busy_err++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    tx_ready = 1'b1;
    check({tag, "_words"},    got,      int'(n));
    check({tag, "_issued"},   issued,   int'(n));
    check({tag, "_data"},     data_err, 0);
    check({tag, "_addr"},     addr_err, 0);
    check({tag, "_last"},     last_err, 0);
    check({tag, "_stable"},   unstable, 0);
    check({tag, "_lead_le2"}, {31'b0, lead_max <= 2}, 32'd1);
    check({tag, "_busy"},     busy_err, 0);
    if (mode == 0) begin
      check({tag, "_done_cyc"}, done_cyc, (n == 0) ? 1 : int'(n) + 3);
      if (n != 0) begin
        check({tag, "_first_cyc"}, first_cyc, 3);
        check({tag, "_last_cyc"},  last_cyc,  int'(n) + 2);
      end
    end else begin
      check({tag, "_done_seen"}, {31'b0, done_cyc > 0}, 32'd1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("idle");

    run("basic",   8'h10, 9'd4,   0, 0);
    run("wrap",    8'hFE, 9'd4,   0, 0);
    run("stall",   8'h40, 9'd8,   1, 0);
    run("stall2",  8'hC3, 9'd8,   1, 0);
    run("zero",    8'h55, 9'd0,   0, 0);
    run("full",    8'h8F, 9'd256, 0, 100);

    // Abort after three of six words have been delivered.
    @(posedge clk); #1;
    base_addr = 8'h30; len = 9'd6; start = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    check_reset_outputs("abort_next");
    run("after_rst", 8'h20, 9'd2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
